// File: rtl/lm_display_sequencer_pkg.sv
// Shared LED-manager definitions: display modes, sequencer states and timing defaults.
package lm_display_sequencer_pkg;

  localparam int unsigned LM_MODE_W          = 2;
  localparam int unsigned LM_HOLD_CYCLES_DEF = 50_000_000;
  localparam int unsigned LM_BLINK_HALF_DEF  = 25_000_000;
  localparam int unsigned LM_CNT_W_DEF       = 26;

  typedef enum logic [LM_MODE_W-1:0] {
    LM_MODE_DIRECT = 2'b00,
    LM_MODE_BLINK  = 2'b01,
    LM_MODE_PULSE  = 2'b10,
    LM_MODE_STICKY = 2'b11
  } lm_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LOAD,
    ST_SHOW
  } lm_state_e;

  // True when a countdown starting at value-1 fits in width bits (and value >= 1).
  function automatic bit lm_cnt_fits(int unsigned value, int unsigned width);
    return (64'(value) - 64'd1) < (64'd1 << width);
  endfunction

endpackage

// File: rtl/lm_display_sequencer_if.sv
// Read side of the LM request FIFO: entry data, empty flag and pop strobe.
interface lm_display_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH+1:0] rd_data;
  logic             fifo_empty;
  logic             rd_en;

  // master pops entries (sequencer); slave is the FIFO.
  modport master (output rd_en, input rd_data, input fifo_empty);
  modport slave  (input rd_en, output rd_data, output fifo_empty);
endinterface

// File: rtl/lm_blink_timer.sv
// Free-running blink phase generator with restart; exposes the phase for the coming cycle.
module lm_blink_timer
  import lm_display_sequencer_pkg::*;
#(
  parameter int unsigned BLINK_HALF = LM_BLINK_HALF_DEF,
  parameter int unsigned CNT_W      = LM_CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic phase_next
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BLINK_HALF - 1);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             phase;

  always_comb begin
    cnt_nxt    = cnt;
    phase_next = phase;
    if (restart) begin
      cnt_nxt    = '0;
      phase_next = 1'b1;
    end else if (en) begin
      if (cnt == HALF_LAST) begin
        cnt_nxt    = '0;
        phase_next = ~phase;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else begin
      cnt   <= cnt_nxt;
      phase <= phase_next;
    end
  end

endmodule

// File: rtl/lm_display_sequencer.sv
// LED manager output stage: pops display requests from the LM FIFO and drives the LEDs
// for at least HOLD_CYCLES per entry in direct, blink, pulse or sticky-error mode.
module lm_display_sequencer
  import lm_display_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned HOLD_CYCLES = LM_HOLD_CYCLES_DEF,
  parameter int unsigned BLINK_HALF  = LM_BLINK_HALF_DEF,
  parameter int unsigned CNT_W       = LM_CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  lm_display_sequencer_if.master       fifo,
  input  logic                         clr_sticky,
  output logic                         busy,
  output logic [WIDTH-1:0]             leds
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  if (!lm_cnt_fits(HOLD_CYCLES, CNT_W) || !lm_cnt_fits(BLINK_HALF, CNT_W)) begin : g_bad_cnt_w
    $error("lm_display_sequencer: CNT_W too small or HOLD_CYCLES/BLINK_HALF zero");
  end

  lm_state_e        state, state_nxt;
  lm_mode_e         mode, mode_nxt, rd_mode;
  logic [WIDTH-1:0] pattern, pattern_nxt, sticky, sticky_nxt, leds_nxt, rd_pat;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic             busy_nxt, pop, phase_next;

  assign rd_mode = lm_mode_e'(fifo.rd_data[WIDTH+1:WIDTH]);
  assign rd_pat  = fifo.rd_data[WIDTH-1:0];

  // pop is a Mealy output; masking with rst keeps it low while reset holds state in IDLE.
  assign fifo.rd_en = pop & ~rst;

  lm_blink_timer #(
    .BLINK_HALF (BLINK_HALF),
    .CNT_W      (CNT_W)
  ) u_blink (
    .clk        (clk),
    .rst        (rst),
    .en         ((state == ST_SHOW) && (mode == LM_MODE_BLINK)),
    .restart    (state == ST_LOAD),
    .phase_next (phase_next)
  );

  always_comb begin
    state_nxt   = state;
    mode_nxt    = mode;
    pattern_nxt = pattern;
    hold_nxt    = hold_cnt;
    sticky_nxt  = clr_sticky ? '0 : sticky;
    leds_nxt    = leds;
    busy_nxt    = 1'b0;
    pop         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo.fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: state_nxt = ST_LOAD;
      ST_LOAD: begin
        mode_nxt    = rd_mode;
        pattern_nxt = rd_pat;
        hold_nxt    = HOLD_LAST;
        busy_nxt    = 1'b1;
        state_nxt   = ST_SHOW;
        // Clear has already been applied to sticky_nxt, so a same-cycle clear yields the new pattern.
        if (rd_mode == LM_MODE_STICKY) begin
          sticky_nxt = (rd_pat == '0) ? '0 : (sticky_nxt | rd_pat);
          leds_nxt   = sticky_nxt;
        end else begin
          leds_nxt = rd_pat;
        end
      end
      ST_SHOW: begin
        busy_nxt = (hold_cnt != '0);
        if (hold_cnt != '0) begin
          hold_nxt = hold_cnt - CNT_W'(1);
        end else if (!fifo.fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_WAIT;
        end else if (mode == LM_MODE_PULSE) begin
          state_nxt = ST_IDLE;
        end
        unique case (mode)
          LM_MODE_DIRECT: leds_nxt = pattern;
          LM_MODE_BLINK:  leds_nxt = phase_next ? pattern : '0;
          LM_MODE_PULSE:  leds_nxt = (state_nxt == ST_IDLE) ? '0 : pattern;
          LM_MODE_STICKY: leds_nxt = sticky_nxt;
        endcase
      end
    endcase
  end

  // busy is registered next to leds, so it is high for exactly the HOLD_CYCLES an entry is shown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      mode     <= LM_MODE_DIRECT;
      pattern  <= '0;
      hold_cnt <= '0;
      sticky   <= '0;
      leds     <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      mode     <= mode_nxt;
      pattern  <= pattern_nxt;
      hold_cnt <= hold_nxt;
      sticky   <= sticky_nxt;
      leds     <= leds_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule
